// File: rtl/dram_ring_arbiter.sv
// Arbitrates the single DRAM command port between the ring-buffer writer and reader.
// Owns ring pointers, occupancy/full/empty, outstanding-read tracking and overflow count.
module dram_ring_arbiter #(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned RING_DEPTH = 16777216,
    parameter int unsigned MAX_OUT    = 8,
    parameter int unsigned OVERWRITE  = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              wr_req_i,
    input  logic              rd_req_i,
    output logic              wr_grant_o,
    output logic              rd_grant_o,
    output logic [ADDR_W-1:0] dram_addr_o,
    output logic              dram_rwn_o,
    output logic              dram_cmd_valid_o,
    input  logic              dram_ready_i,
    input  logic              rd_val_i,
    output logic [ADDR_W:0]   occupancy_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [7:0]        outstanding_o,
    output logic [15:0]       overflow_cnt_o,
    output logic [1:0]        state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARB   = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(RING_DEPTH - 1);
    localparam logic [ADDR_W:0]   OCC_FULL  = (ADDR_W + 1)'(RING_DEPTH);
    localparam logic [7:0]        MAX_OUT_C = 8'(MAX_OUT);
    localparam logic              OVR_EN    = (OVERWRITE != 0);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [7:0]        out_q, out_d;
    logic [15:0]       ovf_q, ovf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rwn_q, rwn_d;
    logic              valid_q, valid_d;
    logic              last_rd_q, last_rd_d;

    logic              wr_elig;
    logic              rd_elig;
    logic              pick_wr;
    logic              rd_accept;
    logic              rd_ret;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + ADDR_W'(1);
    endfunction

    // Acceptance happens in the cycle dram_ready meets the held command.
    assign wr_grant_o       = valid_q & dram_ready_i & ~rwn_q;
    assign rd_grant_o       = valid_q & dram_ready_i & rwn_q;
    assign dram_addr_o      = addr_q;
    assign dram_rwn_o       = rwn_q;
    assign dram_cmd_valid_o = valid_q;
    assign occupancy_o      = occ_q;
    assign full_o           = full_q;
    assign empty_o          = empty_q;
    assign outstanding_o    = out_q;
    assign overflow_cnt_o   = ovf_q;
    assign state_o          = state_q;

    // Next-state, command and bookkeeping logic.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        ovf_d     = ovf_q;
        addr_d    = addr_q;
        rwn_d     = rwn_q;
        valid_d   = valid_q;
        last_rd_d = last_rd_q;

        wr_elig   = wr_req_i & (~full_q | OVR_EN);
        rd_elig   = rd_req_i & ~empty_q & (out_q < MAX_OUT_C);
        // On a tie the writer wins only if the reader was granted last.
        pick_wr   = wr_elig & (~rd_elig | last_rd_q);
        rd_accept = valid_q & dram_ready_i & rwn_q;
        rd_ret    = rd_val_i & (out_q != 8'd0);

        case (state_q)
            S_IDLE: begin
                if (en_i) state_d = S_ARB;
            end
            S_ARB: begin
                if (!en_i) begin
                    state_d = S_IDLE;
                end else if (wr_elig | rd_elig) begin
                    addr_d  = pick_wr ? wr_ptr_q : rd_ptr_q;
                    rwn_d   = ~pick_wr;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dram_ready_i) begin
                    valid_d   = 1'b0;
                    state_d   = en_i ? S_ARB : S_IDLE;
                    last_rd_d = rwn_q;
                    if (rwn_q) begin
                        rd_ptr_d = next_ptr(rd_ptr_q);
                        occ_d    = occ_q - (ADDR_W + 1)'(1);
                    end else begin
                        wr_ptr_d = next_ptr(wr_ptr_q);
                        if (full_q) begin
                            rd_ptr_d = next_ptr(rd_ptr_q);
                            if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
                        end else begin
                            occ_d = occ_q + (ADDR_W + 1)'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_d   = out_q + 8'(rd_accept) - 8'(rd_ret);
        full_d  = (occ_d == OCC_FULL);
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            out_q     <= '0;
            ovf_q     <= '0;
            addr_q    <= '0;
            rwn_q     <= 1'b1;
            valid_q   <= 1'b0;
            last_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
            addr_q    <= addr_d;
            rwn_q     <= rwn_d;
            valid_q   <= valid_d;
            last_rd_q <= last_rd_d;
        end
    end

endmodule

// File: tb/tb_dram_ring_arbiter.sv
// Scoreboard bench for dram_ring_arbiter: a blocking-mode instance (depth 4, 2 outstanding)
// and an overwrite-mode instance (depth 4) with expected grants queued ahead of each phase.
module tb_dram_ring_arbiter;

    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: RING_DEPTH=4, MAX_OUT=2, OVERWRITE=0
    logic          rst_n, en, wr_req, rd_req, dram_ready, rdv_man, auto_en;
    logic [2:0]    ret_sr;
    logic          rd_val;
    logic          wr_grant, rd_grant, dram_rwn, dram_cmd_valid, full, empty;
    logic [AW-1:0] dram_addr;
    logic [AW:0]   occupancy;
    logic [7:0]    outstanding;
    logic [15:0]   overflow_cnt;
    logic [1:0]    state;

    // Instance B: RING_DEPTH=4, OVERWRITE=1
    logic          b_rst_n, b_en, b_wr_req, b_rd_req, b_ready, b_rd_val;
    logic          b_wr_grant, b_rd_grant, b_rwn, b_valid, b_full, b_empty;
    logic [AW-1:0] b_addr;
    logic [AW:0]   b_occ;
    logic [7:0]    b_outst;
    logic [15:0]   b_ovf;
    logic [1:0]    b_state;

    assign rd_val = rdv_man | ret_sr[2];

    // Reads come back three cycles after their grant when auto_en is set.
    always @(posedge clk) ret_sr <= {ret_sr[1:0], rd_grant & auto_en};

    dram_ring_arbiter #(.ADDR_W(AW), .RING_DEPTH(4), .MAX_OUT(2), .OVERWRITE(0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .wr_req_i(wr_req), .rd_req_i(rd_req),
        .wr_grant_o(wr_grant), .rd_grant_o(rd_grant), .dram_addr_o(dram_addr),
        .dram_rwn_o(dram_rwn), .dram_cmd_valid_o(dram_cmd_valid), .dram_ready_i(dram_ready),
        .rd_val_i(rd_val), .occupancy_o(occupancy), .full_o(full), .empty_o(empty),
        .outstanding_o(outstanding), .overflow_cnt_o(overflow_cnt), .state_o(state)
    );

    dram_ring_arbiter #(.ADDR_W(AW), .RING_DEPTH(4), .MAX_OUT(8), .OVERWRITE(1)) u_dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .en_i(b_en), .wr_req_i(b_wr_req), .rd_req_i(b_rd_req),
        .wr_grant_o(b_wr_grant), .rd_grant_o(b_rd_grant), .dram_addr_o(b_addr),
        .dram_rwn_o(b_rwn), .dram_cmd_valid_o(b_valid), .dram_ready_i(b_ready),
        .rd_val_i(b_rd_val), .occupancy_o(b_occ), .full_o(b_full), .empty_o(b_empty),
        .outstanding_o(b_outst), .overflow_cnt_o(b_ovf), .state_o(b_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Grant encoding: {rd_grant, wr_grant, rwn, addr[7:0]}
    logic [31:0] exp_q[$];
    logic [31:0] b_q[$];
    int          gcnt = 0;
    int          b_gcnt = 0;
    int          last_g = -1;

    task automatic push_w(input int a, input bit sb);
        if (sb) b_q.push_back(32'h200 + 32'(a));
        else    exp_q.push_back(32'h200 + 32'(a));
    endtask

    task automatic push_r(input int a, input bit sb);
        if (sb) b_q.push_back(32'h500 + 32'(a));
        else    exp_q.push_back(32'h500 + 32'(a));
    endtask

    always @(negedge clk) begin
        logic [31:0] got, exp;
        if (rst_n && (wr_grant || rd_grant)) begin
            got = 32'({rd_grant, wr_grant, dram_rwn, 8'(dram_addr)});
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
            check("grant_a", got, exp);
            if (last_g >= 0) check("grant_gap", 32'((cyc - last_g) >= 2), 32'd1);
            last_g = cyc;
            gcnt++;
        end
    end

    always @(negedge clk) begin
        logic [31:0] got, exp;
        if (b_rst_n && (b_wr_grant || b_rd_grant)) begin
            got = 32'({b_rd_grant, b_wr_grant, b_rwn, 8'(b_addr)});
            exp = (b_q.size() > 0) ? b_q.pop_front() : 32'hDEAD;
            check("grant_b", got, exp);
            b_gcnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gr(input bit sb, input int n, input string tag);
        int target;
        int k;
        target = (sb ? b_gcnt : gcnt) + n;
        k = 0;
        while ((sb ? b_gcnt : gcnt) < target && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, "_grants"}, 32'(sb ? b_gcnt : gcnt), 32'(target));
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!dram_cmd_valid && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, 32'(dram_cmd_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; wr_req = 1'b0; rd_req = 1'b0; dram_ready = 1'b0;
        rdv_man = 1'b0; auto_en = 1'b0; ret_sr = 3'b000;
        b_rst_n = 1'b0; b_en = 1'b0; b_wr_req = 1'b0; b_rd_req = 1'b0; b_ready = 1'b0;
        b_rd_val = 1'b0;
        repeat (3) tick();

        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(dram_cmd_valid), 32'd0);
        check("rst_rwn", 32'(dram_rwn), 32'd1);
        check("rst_addr", 32'(dram_addr), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_outst", 32'(outstanding), 32'd0);
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        check("rst_grants", 32'({wr_grant, rd_grant}), 32'd0);
        rst_n = 1'b1; b_rst_n = 1'b1;
        tick();

        // Fill to full, then no further write grant
        for (int a = 0; a < 4; a++) push_w(a, 1'b0);
        en = 1'b1; dram_ready = 1'b1; wr_req = 1'b1;
        wait_gr(1'b0, 4, "fill");
        tick(); repeat (6) tick();
        wr_req = 1'b0;
        check("fill_full", 32'(full), 32'd1);
        check("fill_occ", 32'(occupancy), 32'd4);
        check("fill_state_arb", 32'(state), 32'd1);

        // Drain with returns, pointers wrap to 0
        auto_en = 1'b1;
        for (int a = 0; a < 4; a++) push_r(a, 1'b0);
        rd_req = 1'b1;
        wait_gr(1'b0, 4, "drain");
        tick(); rd_req = 1'b0;
        repeat (8) tick();
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_occ", 32'(occupancy), 32'd0);
        check("drain_outst", 32'(outstanding), 32'd0);

        // Bring occupancy to 2 with a read granted last, then tie round-robin
        for (int a = 0; a < 3; a++) push_w(a, 1'b0);
        wr_req = 1'b1;
        wait_gr(1'b0, 3, "pre_w");
        tick(); wr_req = 1'b0; tick();
        push_r(0, 1'b0);
        rd_req = 1'b1;
        wait_gr(1'b0, 1, "pre_r");
        tick(); rd_req = 1'b0; tick();
        check("rr_occ_start", 32'(occupancy), 32'd2);
        push_w(3, 1'b0); push_r(1, 1'b0); push_w(0, 1'b0); push_r(2, 1'b0);
        wr_req = 1'b1; rd_req = 1'b1;
        wait_gr(1'b0, 4, "rr");
        tick(); wr_req = 1'b0; rd_req = 1'b0;
        repeat (8) tick();
        check("rr_occ_end", 32'(occupancy), 32'd2);
        check("rr_outst", 32'(outstanding), 32'd0);

        // Outstanding limit stalls reads until a return arrives
        push_w(1, 1'b0); push_w(2, 1'b0);
        wr_req = 1'b1;
        wait_gr(1'b0, 2, "refill");
        tick(); wr_req = 1'b0; tick();
        check("refill_full", 32'(full), 32'd1);
        auto_en = 1'b0;
        push_r(3, 1'b0); push_r(0, 1'b0);
        rd_req = 1'b1;
        wait_gr(1'b0, 2, "maxout");
        repeat (10) tick();
        check("maxout_outst", 32'(outstanding), 32'd2);
        check("maxout_occ", 32'(occupancy), 32'd2);
        check("maxout_stall", 32'(dram_cmd_valid), 32'd0);
        push_r(1, 1'b0);
        rdv_man = 1'b1; tick(); rdv_man = 1'b0;
        wait_gr(1'b0, 1, "maxout_resume");
        tick(); rd_req = 1'b0; tick();
        check("resume_outst", 32'(outstanding), 32'd2);
        check("resume_occ", 32'(occupancy), 32'd1);
        rdv_man = 1'b1;
        repeat (3) tick();
        rdv_man = 1'b0;
        check("no_underflow", 32'(outstanding), 32'd0);

        // Command held through dram_ready low; en dropped mid-way
        push_w(3, 1'b0);
        dram_ready = 1'b0; wr_req = 1'b1;
        wait_valid("hold");
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(dram_cmd_valid), 32'd1);
            check("hold_addr", 32'({dram_rwn, 8'(dram_addr)}), 32'h003);
            check("hold_nogrant", 32'(wr_grant), 32'd0);
            if (i == 2) en = 1'b0;
            tick();
        end
        dram_ready = 1'b1;
        wait_gr(1'b0, 1, "hold");
        tick(); wr_req = 1'b0;
        check("hold_idle", 32'(state), 32'd0);
        check("hold_valid_drop", 32'(dram_cmd_valid), 32'd0);
        check("hold_occ", 32'(occupancy), 32'd2);

        // Asynchronous reset while a command is pending
        en = 1'b1; dram_ready = 1'b0; rd_req = 1'b1;
        wait_valid("arst");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(dram_cmd_valid), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_addr", 32'({dram_rwn, 8'(dram_addr)}), 32'h100);
        check("arst_grant", 32'(rd_grant), 32'd0);
        rd_req = 1'b0; en = 1'b0;
        tick(); rst_n = 1'b1; tick();

        // Overwrite mode: fifth write lands on address 0 and drops the oldest word
        for (int a = 0; a < 4; a++) push_w(a, 1'b1);
        push_w(0, 1'b1);
        b_en = 1'b1; b_ready = 1'b1; b_wr_req = 1'b1;
        wait_gr(1'b1, 5, "ovr");
        tick(); b_wr_req = 1'b0; tick();
        check("ovr_occ", 32'(b_occ), 32'd4);
        check("ovr_full", 32'(b_full), 32'd1);
        check("ovr_cnt", 32'(b_ovf), 32'd1);
        push_r(1, 1'b1);
        b_rd_req = 1'b1;
        wait_gr(1'b1, 1, "ovr_rd");
        tick(); b_rd_req = 1'b0; tick();
        check("ovr_rd_occ", 32'(b_occ), 32'd3);
        check("ovr_rd_outst", 32'(b_outst), 32'd1);

        repeat (4) tick();
        check("sb_a_left", 32'(exp_q.size()), 32'd0);
        check("sb_b_left", 32'(b_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_ring_arbiter.md
Name: dram_ring_arbiter

Overview:
- Sequences the single DRAM command port of the ring buffer between the capture writer and the readout reader.
- Owns the ring write/read pointers, occupancy, full/empty and overflow status.
- Tracks outstanding read returns so the reader never has more reads in flight than the BRAM path can absorb.
- Sits between the capture/readout controllers and the DRAM controller command interface.

Parameters:
ADDR_W, 24, width of DRAM word address and pointers.
RING_DEPTH, 16777216, ring size in DRAM words (1..2^ADDR_W); pointers wrap to 0 at RING_DEPTH-1.
MAX_OUT, 8, max read commands issued but not yet returned via rd_val (1..255).
OVERWRITE, 0, 1 = write accepted when full (oldest word dropped); 0 = write blocked when full.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
en  in  1  arbiter enable; 0 = no new grants
wr_req  in  1  writer requests one DRAM write command (level, held until wr_grant)
rd_req  in  1  reader requests one DRAM read command (level, held until rd_grant)
wr_grant  out  1  1-cycle pulse: write command accepted by DRAM
rd_grant  out  1  1-cycle pulse: read command accepted by DRAM
dram_addr  out  ADDR_W  command address (wr_ptr or rd_ptr)
dram_rwn  out  1  1 = read, 0 = write
dram_cmd_valid  out  1  command valid to DRAM controller
dram_ready  in  1  DRAM accepts command when dram_cmd_valid & dram_ready
rd_val  in  1  one read word returned this cycle
occupancy  out  ADDR_W+1  words written and not yet read
full  out  1  occupancy == RING_DEPTH
empty  out  1  occupancy == 0
outstanding  out  8  read commands awaiting rd_val
overflow_cnt  out  16  writes that overwrote unread data, saturating at 16'hFFFF
state  out  2  FSM state for debug

Behaviour:
- Reset (rst=0, async): state=IDLE; wr_ptr=rd_ptr=0; occupancy=0; outstanding=0; overflow_cnt=0; wr_grant=rd_grant=dram_cmd_valid=0; dram_rwn=1; dram_addr=0; empty=1, full=0.
- FSM states, encoded in this order:
  - IDLE(0): if en -> ARB.
  - ARB(1): if !en -> IDLE. Eligibility:
    - write eligible = wr_req & (!full | OVERWRITE).
    - read eligible = rd_req & !empty & (outstanding < MAX_OUT).
    - If both are eligible, round-robin: grant the side not granted last (last_grant resets to "read", so the writer wins the first tie). Otherwise grant the eligible side.
    - On a grant: latch dram_addr/dram_rwn and go to ISSUE. With no eligible side, stay in ARB.
  - ISSUE(2): dram_cmd_valid=1 with dram_addr/dram_rwn stable. On dram_ready: pulse the matching grant that same cycle, update pointers/counters at that edge, drop dram_cmd_valid, then -> ARB if en, else -> IDLE. en falling in ISSUE does not abort: the command is held until accepted.
- Latency: request sampled in ARB; dram_cmd_valid asserted the next cycle. Minimum 2 cycles per command, so back-to-back accepted commands are at most one every 2 cycles.
- Write accept:
  - wr_ptr advances by 1 and wraps RING_DEPTH-1 -> 0.
  - If not full: occupancy +1.
  - If full (OVERWRITE=1 only): occupancy unchanged, rd_ptr advances (with wrap), overflow_cnt +1 (saturating).
- Read accept: rd_ptr advances with wrap; occupancy -1; outstanding +1.
- rd_val: outstanding -1. When rd_val coincides with a read accept, outstanding is unchanged. rd_val while outstanding==0 is ignored: no underflow.
- Only one command is accepted per cycle, so occupancy never sees simultaneous +1/-1.
- full/empty are combinational from occupancy. Request eligibility is evaluated on the register values at ARB, never on values updated in the same cycle.
- Pointers and occupancy are retained across en=0; only rst clears them.
- A wr_req/rd_req dropped before its grant is not remembered.

Test Plan:
- RING_DEPTH=4, OVERWRITE=0, en=1, hold wr_req -> 4 wr_grant pulses at dram_addr 0,1,2,3, each 2 cycles apart with dram_ready=1; then full=1, occupancy=4, no further grant.
- From full, hold rd_req with rd_val returned 3 cycles after each grant -> 4 rd_grant at addr 0..3, empty=1, outstanding back to 0, rd_ptr=wr_ptr=0 (wrap).
- wr_req and rd_req both held, occupancy=2, dram_ready=1 -> grants alternate W,R,W,R starting with W; occupancy stays 2 or 3.
- MAX_OUT=2, occupancy=4, rd_req held, rd_val=0 -> exactly 2 rd_grant, outstanding=2, then stall. One rd_val pulse -> third grant issued.
- OVERWRITE=1, full, one write -> wr_grant at addr 0, occupancy=4, rd_ptr=1, overflow_cnt=1.
- dram_ready=0 for 5 cycles in ISSUE, en dropped mid-way -> dram_cmd_valid and addr stable, grant on the ready cycle, then IDLE. Asserting rst low in ISSUE -> all outputs at reset values immediately, without waiting for a clock edge.
